// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper and its scoreboard.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_e;

  localparam int SETTLE_W = 4;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_tt_scoreboard.sv
// Accumulates sampled output bits into a captured truth table and tracks mismatches.
module tt_scoreboard
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN = 4,
  localparam int T   = tt_width(N_IN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            smp_i,
  input  logic [N_IN-1:0] idx_i,
  input  logic            bit_i,
  input  logic            exp_i,
  output logic [T-1:0]    captured_o,
  output logic [N_IN:0]   mismatch_cnt_o,
  output logic [N_IN-1:0] first_fail_o
);

  logic [T-1:0]    captured_q, captured_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            seen_q, seen_d;

  always_comb begin
    captured_d = captured_q;
    cnt_d      = cnt_q;
    ff_d       = ff_q;
    seen_d     = seen_q;
    if (clr_i) begin
      captured_d = '0;
      cnt_d      = '0;
      ff_d       = '0;
      seen_d     = 1'b0;
    end else if (smp_i) begin
      captured_d[idx_i] = bit_i;
      if (bit_i != exp_i) begin
        cnt_d = cnt_q + 1'b1;
        // Indices arrive in ascending order, so the first miss is the lowest.
        if (!seen_q) begin
          ff_d   = idx_i;
          seen_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      captured_q <= '0;
      cnt_q      <= '0;
      ff_q       <= '0;
      seen_q     <= 1'b0;
    end else begin
      captured_q <= captured_d;
      cnt_q      <= cnt_d;
      ff_q       <= ff_d;
      seen_q     <= seen_d;
    end
  end

  assign captured_o     = captured_q;
  assign mismatch_cnt_o = cnt_q;
  assign first_fail_o   = ff_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector of a combinational block in order, samples its output
// after a settle window, and scores the captured truth table against an expected one.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 0,
  localparam int T     = tt_width(N_IN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [T-1:0]    expected_i,
  output logic [N_IN-1:0] dut_in_o,
  input  logic            dut_out_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [T-1:0]    captured_o,
  output logic [N_IN:0]   mismatch_cnt_o,
  output logic [N_IN-1:0] first_fail_o,
  output logic            pass_o
);

  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE);
  localparam logic [N_IN-1:0]     IDX_LAST    = N_IN'(T - 1);

  state_e                state_q, state_d;
  logic [N_IN-1:0]       idx_q, idx_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [T-1:0]          exp_q, exp_d;
  logic                  pass_q, pass_d;
  logic                  clr, smp;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    exp_d    = exp_q;
    pass_d   = pass_q;
    clr      = 1'b0;
    smp      = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          exp_d    = expected_i;
          clr      = 1'b1;
          pass_d   = 1'b0;
          idx_d    = '0;
          settle_d = SETTLE_INIT;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (abort_i) begin
          pass_d  = 1'b0;
          state_d = IDLE;
        end else if (settle_q != '0) begin
          settle_d = settle_q - 1'b1;
        end else begin
          smp = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d    = idx_q + 1'b1;
            settle_d = SETTLE_INIT;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        pass_d  = (mismatch_cnt_o == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      exp_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      pass_q   <= pass_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign dut_in_o = (state_q == HOLD) ? idx_q : '0;
  // The final count settles on the edge entering DONE, so pass is shown live there.
  assign pass_o   = (state_q == DONE) ? (mismatch_cnt_o == '0) : pass_q;

  tt_scoreboard #(.N_IN(N_IN)) u_sb (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clr_i          (clr),
    .smp_i          (smp),
    .idx_i          (idx_q),
    .bit_i          (dut_out_i),
    .exp_i          (exp_q[idx_q]),
    .captured_o     (captured_o),
    .mismatch_cnt_o (mismatch_cnt_o),
    .first_fail_o   (first_fail_o)
  );

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with SETTLE=0 and a combinational block,
// one with SETTLE=2 and a block whose output is registered by one cycle.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, abort0 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
  logic [15:0] exp0 = '0, exp2 = '0, tt0 = '0, tt2 = '0;
  logic [3:0]  din0, din2;
  logic        dout0, dout2;
  logic        busy0, done0, pass0, busy2, done2, pass2;
  logic [15:0] cap0, cap2;
  logic [4:0]  mm0, mm2;
  logic [3:0]  ff0, ff2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Logic blocks under evaluation, each described by its own truth table.
  assign dout0 = tt0[din0];
  always @(posedge clk) dout2 <= tt2[din2];

  truth_table_sweeper #(.N_IN(4), .SETTLE(0)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .abort_i(abort0), .expected_i(exp0),
    .dut_in_o(din0), .dut_out_i(dout0), .busy_o(busy0), .done_o(done0),
    .captured_o(cap0), .mismatch_cnt_o(mm0), .first_fail_o(ff0), .pass_o(pass0));

  truth_table_sweeper #(.N_IN(4), .SETTLE(2)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .abort_i(abort2), .expected_i(exp2),
    .dut_in_o(din2), .dut_out_i(dout2), .busy_o(busy2), .done_o(done2),
    .captured_o(cap2), .mismatch_cnt_o(mm2), .first_fail_o(ff2), .pass_o(pass2));

  typedef struct {
    string       nm;
    logic [15:0] tt;
    logic [15:0] ex;
    logic [15:0] cap;
    int          cnt;
    int          ff;
    bit          pass;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Reference: the block's truth table is what gets captured; scoring is plain bit counting.
  function automatic void model(input logic [15:0] tt, input logic [15:0] ex,
                                output int cnt, output int ff, output bit pass);
    cnt = 0;
    ff  = -1;
    for (int k = 0; k < 16; k++)
      if (tt[k] != ex[k]) begin
        cnt++;
        if (ff < 0) ff = k;
      end
    if (ff < 0) ff = 0;
    pass = (cnt == 0);
  endfunction

  function automatic logic g_done(input int sel); return sel ? done2 : done0; endfunction
  function automatic logic g_busy(input int sel); return sel ? busy2 : busy0; endfunction
  function automatic logic [3:0] g_din(input int sel); return sel ? din2 : din0; endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start2 = v; else start0 = v;
  endtask

  task automatic sweep(input int sel, input logic [15:0] tt, input logic [15:0] ex,
                       input int repulse, input bit with_abort, output int lat, output bit seq_ok);
    int s;
    s = sel ? 3 : 1;
    if (sel != 0) begin tt2 = tt; exp2 = ex; end else begin tt0 = tt; exp0 = ex; end
    @(negedge clk);
    set_start(sel, 1'b1);
    if (sel == 0) abort0 = with_abort;
    @(negedge clk);
    set_start(sel, 1'b0);
    abort0 = 1'b0;
    lat = 0;
    seq_ok = 1'b1;
    while (!g_done(sel) && lat < 200) begin
      if (g_din(sel) !== 4'(lat / s) || g_busy(sel) !== 1'b1) seq_ok = 1'b0;
      set_start(sel, lat == repulse);
      @(negedge clk);
      lat++;
    end
    set_start(sel, 1'b0);
  endtask

  task automatic check_results(input int sel, input vec_t v);
    string p;
    p = $sformatf("%s/s%0d", v.nm, sel ? 2 : 0);
    check({p, " busy_at_done"}, sel ? busy2 : busy0, 1);
    check({p, " captured"}, sel ? cap2 : cap0, v.cap);
    check({p, " mismatch_cnt"}, sel ? mm2 : mm0, v.cnt);
    check({p, " first_fail"}, sel ? ff2 : ff0, v.ff);
    check({p, " pass"}, sel ? pass2 : pass0, v.pass);
    @(negedge clk);
    check({p, " done_pulse_1cyc"}, g_done(sel), 0);
    check({p, " pass_held"}, sel ? pass2 : pass0, v.pass);
    check({p, " captured_held"}, sel ? cap2 : cap0, v.cap);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   lat, c;
    bit   ok, seen;

    tbl.push_back('{"eq1101",   16'h2000, 16'h2000, 16'h2000, 0,  0,  1'b1});
    tbl.push_back('{"const0",   16'h0000, 16'h2000, 16'h0000, 1,  13, 1'b0});
    tbl.push_back('{"inverted", 16'hDFFF, 16'h2000, 16'hDFFF, 16, 0,  1'b0});
    tbl.push_back('{"lastbit",  16'h0000, 16'h8000, 16'h0000, 1,  15, 1'b0});
    for (int i = 0; i < 6; i++) begin
      v.nm = $sformatf("rand%0d", i);
      v.tt = 16'($urandom);
      v.ex = (i % 3 == 0) ? v.tt : ((i % 3 == 1) ? (v.tt ^ (16'h1 << $urandom_range(15, 0))) : 16'($urandom));
      v.cap = v.tt;
      model(v.tt, v.ex, v.cnt, v.ff, v.pass);
      tbl.push_back(v);
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset dut_in", din0, 0);
    check("reset busy", busy0, 0);
    check("reset done", done0, 0);
    check("reset captured", cap0, 0);
    check("reset mismatch_cnt", mm0, 0);
    check("reset first_fail", ff0, 0);
    check("reset pass", pass0, 0);
    check("reset busy s2", busy2, 0);

    for (int i = 0; i < tbl.size(); i++)
      for (int sel = 0; sel < 2; sel++) begin
        // First entry on the SETTLE=0 unit also drives abort with start: start must win.
        sweep(sel, tbl[i].tt, tbl[i].ex, -1, (i == 0 && sel == 0), lat, ok);
        check($sformatf("%s/s%0d latency", tbl[i].nm, sel ? 2 : 0), lat, sel ? 48 : 16);
        check($sformatf("%s/s%0d dut_in_seq", tbl[i].nm, sel ? 2 : 0), ok, 1);
        check_results(sel, tbl[i]);
      end

    // Back-to-back: start in the idle cycle right after done.
    sweep(0, 16'h2000, 16'h2000, -1, 1'b0, lat, ok);
    sweep(0, 16'h0000, 16'h2000, -1, 1'b0, lat, ok);
    check("b2b latency", lat, 16);
    check("b2b mismatch_cnt", mm0, 1);

    // Start re-pulse mid-sweep has no effect.
    sweep(0, 16'h2000, 16'h2000, 6, 1'b0, lat, ok);
    check("repulse latency", lat, 16);
    check("repulse dut_in_seq", ok, 1);
    check("repulse captured", cap0, 16'h2000);
    check("repulse pass", pass0, 1);
    @(negedge clk);

    // Abort while vector 5 is driven.
    tt0 = 16'h2000; exp0 = 16'h2000;
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    c = 0;
    while (din0 !== 4'd5 && c < 50) begin @(negedge clk); c++; end
    check("abort reach5", c < 50, 1);
    abort0 = 1'b1; @(negedge clk); abort0 = 1'b0;
    check("abort busy", busy0, 0);
    check("abort dut_in", din0, 0);
    check("abort done", done0, 0);
    check("abort pass", pass0, 0);
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (done0) seen = 1'b1; end
    check("abort no_done", seen, 0);
    sweep(0, 16'hDFFF, 16'h2000, -1, 1'b0, lat, ok);
    check("after_abort latency", lat, 16);
    check("after_abort mismatch_cnt", mm0, 16);
    check("after_abort captured", cap0, 16'hDFFF);

    // Reset while vector 9 is driven.
    @(negedge clk);
    tt0 = 16'h0000; exp0 = 16'h2000;
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    c = 0;
    while (din0 !== 4'd9 && c < 50) begin @(negedge clk); c++; end
    check("rst reach9", c < 50, 1);
    rst = 1'b1; @(negedge clk);
    check("rst dut_in", din0, 0);
    check("rst busy", busy0, 0);
    check("rst done", done0, 0);
    check("rst captured", cap0, 0);
    check("rst mismatch_cnt", mm0, 0);
    check("rst first_fail", ff0, 0);
    check("rst pass", pass0, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (done0) seen = 1'b1; end
    check("rst no_done", seen, 0);
    sweep(0, 16'h0000, 16'h2000, -1, 1'b0, lat, ok);
    check("after_rst latency", lat, 16);
    check_results(0, tbl[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
